a2d_chnl_seq: RTL and testbench
===============================

# a2d_chnl_seq

Upstream A2D sequencer feeding the LED-mux test top and the balance controller. On each `nxt` strobe it runs six 16-bit SPI frames to the A2D: two per channel, for left load cell, right load cell and battery. It then presents the 12-bit results as registered outputs `lft_ld`, `rght_ld` and `batt`. It contains its own SPI master; no shared SPI block is used.

## Interface
- `LFT_CHNL`, default 3'd0: A2D channel for left load cell
- `RGHT_CHNL`, default 3'd4: A2D channel for right load cell
- `BATT_CHNL`, default 3'd5: A2D channel for battery
- `clk  in  1`: system clock
- `rst_n  in  1`: reset, asynchronous, active-low
- `nxt  in  1`: start strobe; one sequence is requested when sampled high while idle
- `MISO_A2D  in  1`: serial data from A2D
- `lft_ld  out  12`: latest left load cell result
- `rght_ld  out  12`: latest right load cell result
- `batt  out  12`: latest battery result
- `cnv_cmplt  out  1`: one-clk pulse when a full sequence finishes
- `SS_n_A2D  out  1`: active-low slave select
- `SCLK_A2D  out  1`: SPI clock, clk/32, idles high
- `MOSI_A2D  out  1`: serial command to A2D, MSB first

## Operation
- **States:** IDLE, FRAME, GAP. Internal counters: channel index `ci` (0=left, 1=right, 2=batt) and phase `ph` (0=A, 1=B).
- **IDLE:**
  - `nxt` high at an edge moves to FRAME with `ci=0`, `ph=0`.
  - `nxt` is ignored in FRAME and GAP. No queuing.
- **Command word** for both frames of a channel: {2'b00, CHNL[2:0], 11'h000}.
  - Frame A sets the A2D mux.
  - Frame B shifts out the conversion; result = received bits [11:0]. Bits [15:12] are discarded.
- **End of frame B:**
  - Writes the result to the register selected by `ci`.
  - Other result registers hold.
- **After each frame:**
  - If the frame was not the final (`ci=2`, `ph=1`) frame, go to GAP, then back to FRAME with `{ci,ph}` advanced.
  - After the final frame, go to IDLE and pulse `cnv_cmplt`.
- **Output validity:** result registers are always valid. They hold the previous value until overwritten; there is no partial-word visibility.
- **Reset values:**
  - `lft_ld`, `rght_ld`, `batt` = 12'h000
  - `cnv_cmplt` = 0
  - `SS_n_A2D` = 1, `SCLK_A2D` = 1, `MOSI_A2D` = 0
  - State IDLE, counters 0
- **Reset mid-frame:**
  - All of the above apply immediately (asynchronously).
  - The aborted channel's register keeps its reset value 0.
  - No completion pulse.

## Timing
- **Frame start:** `nxt` sampled at edge t0 causes `SS_n_A2D` to go low at t0+1.
- **Frame length:** `SS_n_A2D` stays low for exactly 512 clks (16 bit periods × 32).
- **Bit period k (0..15),** at clk offsets relative to the SS_n fall:
  - SCLK low for [32k, 32k+15].
  - SCLK high for [32k+16, 32k+31].
- **MOSI:**
  - Holds command bit 15−k for the whole of period k.
  - Bit 15 is driven on the same clk `SS_n_A2D` falls.
  - Bits change only while SCLK is high→low (period boundary).
- **MISO:** sampled on the clk at which SCLK goes 0→1 (offset 32k+16), into a 16-bit shift register, MSB first.
- **Frame end:**
  - After the 16th high phase, `SS_n_A2D` returns high.
  - SCLK is already high and remains high.
  - The result register update occurs on this same clk edge (frame B only).
- **GAP:**
  - `SS_n_A2D` high for exactly 32 clks before the next fall.
  - MOSI returns to 0 in GAP and IDLE.
- **Whole sequence:**
  - 6×512 + 5×32 = 3232 clks from first SS_n fall to final SS_n rise.
  - `cnv_cmplt` is high for the single clk on which `batt` updates.
  - `nxt` is accepted again from the next clk.
- **Free-running strobe:** a 19-bit all-ones strobe period (524288) far exceeds 3232, so no overrun occurs in the top.

## Test plan
- **Reset values:** assert `rst_n` low, release, idle 100 clks. Required:
  - all results 0, `SS_n_A2D`=1, `SCLK_A2D`=1, `MOSI_A2D`=0
  - no activity without `nxt`
- **Single sequence:** A2D model returns 12'hA5C (left), 12'h3F1 (right), 12'hC07 (battery), each with upper nibble 4'hF. Pulse `nxt` once. Required:
  - six frames
  - MOSI commands 16'h0000 ×2, 16'h2000 ×2, 16'h2800 ×2
  - outputs 12'hA5C / 12'h3F1 / 12'hC07
  - one `cnv_cmplt` pulse 3233 clks after `nxt`
- **SCLK/SS_n timing:** check within the first frame:
  - SS_n low 512 clks
  - SCLK 16 low + 16 high clks per bit, exactly 16 rising edges
  - 32-clk gap between frames
  - MOSI stable while SCLK high
- **`nxt` while busy:** hold `nxt` high continuously. Required:
  - back-to-back sequences only after each `cnv_cmplt`, with `nxt` re-accepted on the clk after the pulse
  - no extra or truncated frames
- **Reset mid-operation:** assert `rst_n` during the 4th frame (right, phase B), when the left result is already 12'hA5C. Required:
  - SS_n high and all results 0 immediately
  - a subsequent `nxt` produces a full correct sequence
- **Partial update:** model changes its battery value to 12'h7FF between sequences. Required:
  - `batt` changes only at the end of frame 6
  - `lft_ld` and `rght_ld` are rewritten with unchanged values, with no glitch

Source files
------------

// File: rtl/a2d_chnl_seq.sv
// rtl/a2d_chnl_seq.sv - three-channel A2D sequencer with its own SPI master
// Six 16-bit frames per nxt strobe (mux-set then read per channel), registered 12-bit results.
module a2d_chnl_seq #(
    parameter logic [2:0] LFT_CHNL  = 3'd0,
    parameter logic [2:0] RGHT_CHNL = 3'd4,
    parameter logic [2:0] BATT_CHNL = 3'd5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    input  logic        MISO_A2D,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] batt,
    output logic        cnv_cmplt,
    output logic        SS_n_A2D,
    output logic        SCLK_A2D,
    output logic        MOSI_A2D
);
    typedef enum logic [1:0] {IDLE, FRAME, GAP} state_t;

    localparam logic [9:0] FRAME_END = 10'd512;
    // GAP leaves one clk early because FRAME spends its first clk before SS_n falls.
    localparam logic [9:0] GAP_LAST  = 10'd30;

    state_t      state_q, state_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [1:0]  ci_q, ci_d;
    logic        ph_q, ph_d;
    logic [11:0] shift_q, shift_d;
    logic [11:0] lft_q, lft_d;
    logic [11:0] rght_q, rght_d;
    logic [11:0] batt_q, batt_d;
    logic        cmplt_q, cmplt_d;
    logic        ss_n_q, ss_n_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic [2:0]  chnl;
    logic [15:0] cmd;
    logic        last_frame;

    always_comb begin
        case (ci_q)
            2'd0:    chnl = LFT_CHNL;
            2'd1:    chnl = RGHT_CHNL;
            default: chnl = BATT_CHNL;
        endcase
    end

    assign cmd        = {2'b00, chnl, 11'h000};
    assign last_frame = (ci_q == 2'd2) && ph_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ci_q    <= '0;
            ph_q    <= 1'b0;
            shift_q <= '0;
            lft_q   <= '0;
            rght_q  <= '0;
            batt_q  <= '0;
            cmplt_q <= 1'b0;
            ss_n_q  <= 1'b1;
            sclk_q  <= 1'b1;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ci_q    <= ci_d;
            ph_q    <= ph_d;
            shift_q <= shift_d;
            lft_q   <= lft_d;
            rght_q  <= rght_d;
            batt_q  <= batt_d;
            cmplt_q <= cmplt_d;
            ss_n_q  <= ss_n_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ci_d    = ci_q;
        ph_d    = ph_q;
        shift_d = shift_q;
        lft_d   = lft_q;
        rght_d  = rght_q;
        batt_d  = batt_q;
        cmplt_d = 1'b0;
        ss_n_d  = 1'b1;
        sclk_d  = 1'b1;
        mosi_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (nxt) begin
                    state_d = FRAME;
                    cnt_d   = '0;
                    ci_d    = '0;
                    ph_d    = 1'b0;
                end
            end
            FRAME: begin
                if (cnt_q == FRAME_END) begin
                    if (ph_q) begin
                        case (ci_q)
                            2'd0:    lft_d  = shift_q;
                            2'd1:    rght_d = shift_q;
                            2'd2:    batt_d = shift_q;
                            default: ;
                        endcase
                    end
                    cnt_d = '0;
                    if (last_frame) begin
                        state_d = IDLE;
                        cmplt_d = 1'b1;
                        ci_d    = '0;
                        ph_d    = 1'b0;
                    end else begin
                        state_d = GAP;
                        ph_d    = ~ph_q;
                        if (ph_q)
                            ci_d = ci_q + 2'd1;
                    end
                end else begin
                    // cnt_q is the clk offset from the SS_n fall: [8:5] bit period, [4] SCLK phase.
                    ss_n_d = 1'b0;
                    sclk_d = cnt_q[4];
                    mosi_d = cmd[4'd15 - cnt_q[8:5]];
                    // Only the low 12 bits are kept; the upper nibble shifts out the top.
                    if (cnt_q[4:0] == 5'd16)
                        shift_d = {shift_q[10:0], MISO_A2D};
                    cnt_d = cnt_q + 10'd1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = FRAME;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign lft_ld    = lft_q;
    assign rght_ld   = rght_q;
    assign batt      = batt_q;
    assign cnv_cmplt = cmplt_q;
    assign SS_n_A2D  = ss_n_q;
    assign SCLK_A2D  = sclk_q;
    assign MOSI_A2D  = mosi_q;
endmodule

// File: tb/tb_a2d_chnl_seq.sv
// tb/tb_a2d_chnl_seq.sv - scoreboard bench for a2d_chnl_seq
// A2D model answers each frame with {4'hF, value of channel addressed by the previous frame}.
`timescale 1ns/1ps
module tb_a2d_chnl_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        nxt = 1'b0;
    logic        MISO_A2D = 1'b0;
    logic [11:0] lft_ld, rght_ld, batt;
    logic        cnv_cmplt, SS_n_A2D, SCLK_A2D, MOSI_A2D;

    int pass_cnt = 0;
    int total_cnt = 0;

    a2d_chnl_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .nxt      (nxt),
        .MISO_A2D (MISO_A2D),
        .lft_ld   (lft_ld),
        .rght_ld  (rght_ld),
        .batt     (batt),
        .cnv_cmplt(cnv_cmplt),
        .SS_n_A2D (SS_n_A2D),
        .SCLK_A2D (SCLK_A2D),
        .MOSI_A2D (MOSI_A2D)
    );

    always #5 clk = ~clk;

    logic [11:0] lft_val  = 12'hA5C;
    logic [11:0] rght_val = 12'h3F1;
    logic [11:0] batt_val = 12'hC07;

    typedef struct packed {
        logic [11:0] l;
        logic [11:0] r;
        logic [11:0] b;
    } res_t;

    res_t        exp_res_q[$];
    logic [15:0] exp_cmd_q[$];
    logic [15:0] obs_cmd_q[$];
    int          ss_len_q[$];
    int          rise_q[$];
    int          gap_len_q[$];
    int          sclk_bad = 0, mosi_bad = 0, mosi_idle_bad = 0;

    logic        ss_prev = 1'b1, sclk_prev = 1'b1, mosi_prev = 1'b0;
    int          ss_low_run = 0, ss_high_run = 0, sclk_run = 0, rises = 0, bit_idx = 0;
    logic [15:0] cmd_sh = '0, resp = '0;
    logic [2:0]  prev_ch = '0;

    function automatic logic [11:0] a2d_val(input logic [2:0] ch);
        case (ch)
            3'd0:    return lft_val;
            3'd4:    return rght_val;
            3'd5:    return batt_val;
            default: return 12'h000;
        endcase
    endfunction

    // A2D model plus SPI waveform monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (ss_prev && SS_n_A2D === 1'b0) begin
            gap_len_q.push_back(ss_high_run);
            ss_high_run = 0;
            ss_low_run  = 1;
            rises       = 0;
            sclk_run    = 1;
            if (SCLK_A2D !== 1'b0) sclk_bad++;
            resp     = {4'hF, a2d_val(prev_ch)};
            bit_idx  = 15;
            MISO_A2D = resp[15];
        end else if (SS_n_A2D === 1'b0) begin
            ss_low_run++;
            if (SCLK_A2D === sclk_prev) begin
                sclk_run++;
            end else begin
                if (sclk_run != 16) sclk_bad++;
                sclk_run = 1;
                if (SCLK_A2D === 1'b1) begin
                    rises++;
                    cmd_sh = {cmd_sh[14:0], MOSI_A2D};
                end else if (bit_idx > 0) begin
                    bit_idx--;
                    MISO_A2D = resp[bit_idx];
                end
            end
            if (sclk_prev && SCLK_A2D === 1'b1 && MOSI_A2D !== mosi_prev) mosi_bad++;
        end else if (SS_n_A2D === 1'b1) begin
            if (!ss_prev) begin
                ss_len_q.push_back(ss_low_run);
                rise_q.push_back(rises);
                obs_cmd_q.push_back(cmd_sh);
                prev_ch     = cmd_sh[13:11];
                ss_high_run = 0;
            end
            ss_high_run++;
            if (MOSI_A2D !== 1'b0) mosi_idle_bad++;
        end
        ss_prev   = (SS_n_A2D !== 1'b0);
        sclk_prev = (SCLK_A2D === 1'b1);
        mosi_prev = MOSI_A2D;
    end

    task automatic push_expect();
        res_t e;
        e.l = lft_val;
        e.r = rght_val;
        e.b = batt_val;
        exp_res_q.push_back(e);
        for (int i = 0; i < 2; i++) exp_cmd_q.push_back(16'h0000);
        for (int i = 0; i < 2; i++) exp_cmd_q.push_back(16'h2000);
        for (int i = 0; i < 2; i++) exp_cmd_q.push_back(16'h2800);
    endtask

    // Pulses nxt and waits (bounded) for cnv_cmplt; lat/fall are clk edges after the nxt edge.
    task automatic run_seq(output int lat, output int fall);
        int n;
        n = 0;
        lat = -1;
        fall = -1;
        push_expect();
        nxt = 1'b1;
        while (n < 4000 && lat < 0) begin
            @(negedge clk);
            n++;
            if (n == 1) nxt = 1'b0;
            if (fall < 0 && SS_n_A2D === 1'b0) fall = n - 1;
            if (cnv_cmplt === 1'b1) lat = n - 1;
        end
    endtask

    task automatic test_reset();
        int base;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        base = obs_cmd_q.size();
        repeat (100) @(negedge clk);
        total_cnt++; if (lft_ld !== 12'h000) $display("FAIL reset_lft: got %h expected 000", lft_ld); else pass_cnt++;
        total_cnt++; if (rght_ld !== 12'h000) $display("FAIL reset_rght: got %h expected 000", rght_ld); else pass_cnt++;
        total_cnt++; if (batt !== 12'h000) $display("FAIL reset_batt: got %h expected 000", batt); else pass_cnt++;
        total_cnt++; if (SS_n_A2D !== 1'b1) $display("FAIL reset_ss_n: got %b expected 1", SS_n_A2D); else pass_cnt++;
        total_cnt++; if (SCLK_A2D !== 1'b1) $display("FAIL reset_sclk: got %b expected 1", SCLK_A2D); else pass_cnt++;
        total_cnt++; if (MOSI_A2D !== 1'b0) $display("FAIL reset_mosi: got %b expected 0", MOSI_A2D); else pass_cnt++;
        total_cnt++; if (cnv_cmplt !== 1'b0) $display("FAIL reset_cnv: got %b expected 0", cnv_cmplt); else pass_cnt++;
        total_cnt++; if (obs_cmd_q.size() != base) $display("FAIL reset_idle_frames: got %0d expected %0d", obs_cmd_q.size(), base); else pass_cnt++;
    endtask

    task automatic test_single_sequence();
        int lat, fall, frm, gap, sb, mb, ib;
        res_t e;
        logic [15:0] ec, oc;
        frm = obs_cmd_q.size();
        gap = gap_len_q.size();
        sb = sclk_bad; mb = mosi_bad; ib = mosi_idle_bad;
        run_seq(lat, fall);
        total_cnt++; if (fall != 1) $display("FAIL single_ss_fall: got edge %0d expected 1", fall); else pass_cnt++;
        total_cnt++; if (lat != 3233) $display("FAIL single_latency: got %0d expected 3233", lat); else pass_cnt++;
        e = (exp_res_q.size() > 0) ? exp_res_q.pop_front() : 'x;
        total_cnt++; if (lft_ld !== e.l) $display("FAIL single_lft: got %h expected %h", lft_ld, e.l); else pass_cnt++;
        total_cnt++; if (rght_ld !== e.r) $display("FAIL single_rght: got %h expected %h", rght_ld, e.r); else pass_cnt++;
        total_cnt++; if (batt !== e.b) $display("FAIL single_batt: got %h expected %h", batt, e.b); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (cnv_cmplt !== 1'b0) $display("FAIL single_cnv_width: got %b expected 0", cnv_cmplt); else pass_cnt++;
        repeat (40) @(negedge clk);
        total_cnt++; if (obs_cmd_q.size() - frm != 6) $display("FAIL single_frames: got %0d expected 6", obs_cmd_q.size() - frm); else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            ec = (exp_cmd_q.size() > 0) ? exp_cmd_q.pop_front() : 'x;
            oc = (frm + i < obs_cmd_q.size()) ? obs_cmd_q[frm + i] : 'x;
            total_cnt++; if (oc !== ec) $display("FAIL single_cmd%0d: got %h expected %h", i, oc, ec); else pass_cnt++;
            total_cnt++;
            if (frm + i >= ss_len_q.size() || ss_len_q[frm + i] != 512)
                $display("FAIL single_ss_len%0d: got %0d expected 512", i, (frm + i < ss_len_q.size()) ? ss_len_q[frm + i] : -1);
            else pass_cnt++;
            total_cnt++;
            if (frm + i >= rise_q.size() || rise_q[frm + i] != 16)
                $display("FAIL single_rises%0d: got %0d expected 16", i, (frm + i < rise_q.size()) ? rise_q[frm + i] : -1);
            else pass_cnt++;
        end
        for (int i = 1; i < 6; i++) begin
            total_cnt++;
            if (gap + i >= gap_len_q.size() || gap_len_q[gap + i] != 32)
                $display("FAIL single_gap%0d: got %0d expected 32", i, (gap + i < gap_len_q.size()) ? gap_len_q[gap + i] : -1);
            else pass_cnt++;
        end
        total_cnt++; if (sclk_bad != sb) $display("FAIL single_sclk_phase: got %0d bad runs expected 0", sclk_bad - sb); else pass_cnt++;
        total_cnt++; if (mosi_bad != mb) $display("FAIL single_mosi_stable: got %0d changes expected 0", mosi_bad - mb); else pass_cnt++;
        total_cnt++; if (mosi_idle_bad != ib) $display("FAIL single_mosi_idle: got %0d nonzero expected 0", mosi_idle_bad - ib); else pass_cnt++;
    endtask

    task automatic test_nxt_busy();
        int n, k, frm;
        int c[2];
        res_t e;
        logic [15:0] ec, oc;
        n = 0; k = 0; c[0] = 0; c[1] = 0;
        frm = obs_cmd_q.size();
        push_expect();
        push_expect();
        nxt = 1'b1;
        while (n < 8000 && k < 2) begin
            @(negedge clk);
            n++;
            if (cnv_cmplt === 1'b1) begin
                c[k] = n;
                k++;
                e = (exp_res_q.size() > 0) ? exp_res_q.pop_front() : 'x;
                total_cnt++; if ({lft_ld, rght_ld, batt} !== e) $display("FAIL busy_results%0d: got %h expected %h", k, {lft_ld, rght_ld, batt}, e); else pass_cnt++;
                if (k == 2) nxt = 1'b0;
            end
        end
        nxt = 1'b0;
        total_cnt++; if (k != 2) $display("FAIL busy_done: got %0d completions expected 2", k); else pass_cnt++;
        total_cnt++; if (c[0] - 1 != 3233) $display("FAIL busy_first_latency: got %0d expected 3233", c[0] - 1); else pass_cnt++;
        total_cnt++; if (c[1] - c[0] != 3234) $display("FAIL busy_restart: got %0d expected 3234", c[1] - c[0]); else pass_cnt++;
        repeat (60) @(negedge clk);
        total_cnt++; if (obs_cmd_q.size() - frm != 12) $display("FAIL busy_frames: got %0d expected 12", obs_cmd_q.size() - frm); else pass_cnt++;
        for (int i = 0; i < 12; i++) begin
            ec = (exp_cmd_q.size() > 0) ? exp_cmd_q.pop_front() : 'x;
            oc = (frm + i < obs_cmd_q.size()) ? obs_cmd_q[frm + i] : 'x;
            total_cnt++; if (oc !== ec) $display("FAIL busy_cmd%0d: got %h expected %h", i, oc, ec); else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        int n, frm, lat, fall;
        res_t e;
        logic [15:0] ec, oc;
        n = 0;
        frm = obs_cmd_q.size();
        push_expect();
        nxt = 1'b1;
        while (n < 3000 && !(obs_cmd_q.size() - frm == 3 && SS_n_A2D === 1'b0)) begin
            @(negedge clk);
            n++;
            if (n == 1) nxt = 1'b0;
        end
        repeat (200) @(negedge clk);
        total_cnt++; if (lft_ld !== 12'hA5C) $display("FAIL mid_lft_before: got %h expected a5c", lft_ld); else pass_cnt++;
        total_cnt++; if (SS_n_A2D !== 1'b0) $display("FAIL mid_in_frame4: got ss_n %b expected 0", SS_n_A2D); else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++; if (SS_n_A2D !== 1'b1) $display("FAIL mid_ss_n: got %b expected 1", SS_n_A2D); else pass_cnt++;
        total_cnt++; if (SCLK_A2D !== 1'b1) $display("FAIL mid_sclk: got %b expected 1", SCLK_A2D); else pass_cnt++;
        total_cnt++; if (MOSI_A2D !== 1'b0) $display("FAIL mid_mosi: got %b expected 0", MOSI_A2D); else pass_cnt++;
        total_cnt++; if ({lft_ld, rght_ld, batt} !== 36'h0) $display("FAIL mid_results: got %h expected 0", {lft_ld, rght_ld, batt}); else pass_cnt++;
        exp_res_q.delete();
        exp_cmd_q.delete();
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        total_cnt++; if (cnv_cmplt !== 1'b0) $display("FAIL mid_no_cnv: got %b expected 0", cnv_cmplt); else pass_cnt++;
        total_cnt++; if (rght_ld !== 12'h000) $display("FAIL mid_rght_after: got %h expected 000", rght_ld); else pass_cnt++;
        frm = obs_cmd_q.size();
        run_seq(lat, fall);
        total_cnt++; if (lat != 3233) $display("FAIL mid_rerun_latency: got %0d expected 3233", lat); else pass_cnt++;
        e = (exp_res_q.size() > 0) ? exp_res_q.pop_front() : 'x;
        total_cnt++; if ({lft_ld, rght_ld, batt} !== e) $display("FAIL mid_rerun_results: got %h expected %h", {lft_ld, rght_ld, batt}, e); else pass_cnt++;
        repeat (40) @(negedge clk);
        total_cnt++; if (obs_cmd_q.size() - frm != 6) $display("FAIL mid_rerun_frames: got %0d expected 6", obs_cmd_q.size() - frm); else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            ec = (exp_cmd_q.size() > 0) ? exp_cmd_q.pop_front() : 'x;
            oc = (frm + i < obs_cmd_q.size()) ? obs_cmd_q[frm + i] : 'x;
            total_cnt++; if (oc !== ec) $display("FAIL mid_rerun_cmd%0d: got %h expected %h", i, oc, ec); else pass_cnt++;
        end
    endtask

    task automatic test_partial_update();
        int n, glitches;
        bit done;
        res_t e;
        n = 0; glitches = 0; done = 1'b0;
        batt_val = 12'h7FF;
        push_expect();
        nxt = 1'b1;
        while (n < 4000 && !done) begin
            @(negedge clk);
            n++;
            if (n == 1) nxt = 1'b0;
            if (cnv_cmplt === 1'b1) done = 1'b1;
            else if (lft_ld !== 12'hA5C || rght_ld !== 12'h3F1 || batt !== 12'hC07) glitches++;
        end
        total_cnt++; if (!done) $display("FAIL partial_done: got no cnv_cmplt in %0d clks expected one", n); else pass_cnt++;
        total_cnt++; if (n - 1 != 3233) $display("FAIL partial_latency: got %0d expected 3233", n - 1); else pass_cnt++;
        total_cnt++; if (glitches != 0) $display("FAIL partial_early_change: got %0d changed samples expected 0", glitches); else pass_cnt++;
        e = (exp_res_q.size() > 0) ? exp_res_q.pop_front() : 'x;
        total_cnt++; if (lft_ld !== e.l) $display("FAIL partial_lft: got %h expected %h", lft_ld, e.l); else pass_cnt++;
        total_cnt++; if (rght_ld !== e.r) $display("FAIL partial_rght: got %h expected %h", rght_ld, e.r); else pass_cnt++;
        total_cnt++; if (batt !== e.b) $display("FAIL partial_batt: got %h expected %h", batt, e.b); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_sequence();
        test_nxt_busy();
        test_reset_mid();
        test_partial_update();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
        $fatal(1);
    end
endmodule
